ds_nway_cd_mul: RTL
===================

Name: ds_nway_cd_mul

Overview:
- N-operand deterministic stochastic multiplier built on the clock-division method; successor to the two-input ordered multiplier.
- Each operand is converted to an ordered unary bitstream of length 2^DATA_WIDTH.
- Operand i's stream advances once per full period of operand i-1's stream. All streams are ANDed and the ones are counted, giving the exact integer product.
- Adds a start/busy/done handshake, an en stall, operand latching and an optional zero-operand early exit. Sits behind the per-core wrapper in the arch sweep.

Parameters:
- DATA_WIDTH, 4, bits per operand; operand value x_i in 0..2^DATA_WIDTH-1.
- NUM_INPUTS, 3, operand count (>=2).
- EARLY_ZERO, 1, when 1 a zero operand finishes the operation immediately with result 0.
- OUT_WIDTH (localparam), DATA_WIDTH*NUM_INPUTS, result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; low freezes the running operation.
- start  in  1  operation request, sampled when not busy.
- bin_data_in  in  [DATA_WIDTH-1:0] x [NUM_INPUTS-1:0]  operands (unpacked array), sampled with start.
- bin_data_out  out  OUT_WIDTH  product count, valid while done=1.
- busy  out  1  operation in progress.
- done  out  1  result valid; level signal, held until the next accepted start.

Behaviour:
- Reset (rst=0, async): FSM to IDLE; all counters, operand latches and bin_data_out go to 0; busy=0, done=0. Reset mid-operation aborts with no result.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN: on a clk edge with start=1. Operands are latched, the NUM_INPUTS stream counters cnt_i (DATA_WIDTH bits each) are zeroed, the accumulator is zeroed, done<=0, busy<=1.
  - In DONE, an accepted start clears done on the same edge.
- RUN, each edge with en=1:
  - Stream bit s_i = (cnt_i < x_i). Accumulator += AND of all s_i.
  - cnt_0 increments every cycle. cnt_i increments only when cnt_0..cnt_{i-1} are all at max (ripple carry), so cnt_0..cnt_{N-1} form one OUT_WIDTH-bit odometer.
  - RUN lasts exactly 2^OUT_WIDTH enabled cycles. On the edge that processes the final odometer value (all counters at max), the FSM goes to DONE, bin_data_out <= final accumulator, busy<=0, done<=1.
- en=0 in RUN: counters, accumulator and state hold; busy stays 1. en has no effect in IDLE/DONE, and start acceptance does not depend on en.
- Latency: start accepted at edge T, en held high -> done=1 visible after edge T+2^OUT_WIDTH. Each en=0 cycle adds one cycle.
- Early zero (EARLY_ZERO=1): if any latched x_i==0, RUN lasts one cycle: done=1 after edge T+1, result 0. With EARLY_ZERO=0 the full period runs and the result is still 0.
- Arithmetic:
  - Result = product of x_i, exact.
  - Maximum result (2^DATA_WIDTH-1)^NUM_INPUTS < 2^OUT_WIDTH, so the accumulator never overflows.
  - Accumulator is OUT_WIDTH bits and wraps silently only if misparametrised, which cannot happen with the derived width.
- start while busy=1 is ignored. Operand changes during RUN have no effect.
- bin_data_out holds its last result through IDLE/DONE and the next RUN, and updates only when DONE is entered.

Test Plan:
- DATA_WIDTH=2, NUM_INPUTS=2, operands {3,2}, start one cycle, en=1 -> done rises 16 cycles after start edge, bin_data_out=6, busy high for exactly 16 cycles.
- Defaults, operands {15,15,15} -> done after 4096 cycles, bin_data_out=3375. Then {5,7,9} -> 315; done drops on the second start edge.
- Defaults, EARLY_ZERO=1, operands {9,0,4} -> done one cycle after start, bin_data_out=0. Repeat with EARLY_ZERO=0 -> 0 after 4096 cycles.
- DATA_WIDTH=2, NUM_INPUTS=2, {3,3}, en toggled low for 5 cycles mid-run -> done after 21 cycles, bin_data_out=9. start pulsed with {1,1} during the run -> ignored, result still 9.
- Assert rst=0 asynchronously mid-run (between clock edges) -> busy, done and bin_data_out go to 0 immediately. After release, start {2,3} -> 6.

Source files
------------

// File: rtl/ds_nway_cd_mul_if.sv
// Handshake and data bundle for the N-operand clock-division stochastic multiplier.
interface ds_nway_cd_mul_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_INPUTS = 3
);
    localparam int unsigned OUT_WIDTH = DATA_WIDTH * NUM_INPUTS;

    logic                  en;
    logic                  start;
    logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS];
    logic [OUT_WIDTH-1:0]  bin_data_out;
    logic                  busy;
    logic                  done;

    modport master (
        output en, start, bin_data_in,
        input  bin_data_out, busy, done
    );

    modport slave (
        input  en, start, bin_data_in,
        output bin_data_out, busy, done
    );
endinterface

// File: rtl/ds_nway_cd_mul.sv
// N-operand deterministic stochastic multiplier: ordered unary streams, clock-division
// advance, AND of all streams counted over 2^OUT_WIDTH cycles gives the exact product.
module ds_nway_cd_mul #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_INPUTS = 3,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input logic            clk,
    input logic            rst,
    ds_nway_cd_mul_if.slave bus
);
    localparam int unsigned OUT_WIDTH = DATA_WIDTH * NUM_INPUTS;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] x_d [NUM_INPUTS];
    // Stream counters packed as one odometer: cnt_i is slice i, ripple carry is plain +1.
    logic [OUT_WIDTH-1:0]  odo_q, odo_d;
    logic [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic [OUT_WIDTH-1:0]  result_q, result_d;
    logic                  stream_and;
    logic                  any_zero;
    logic                  last;

    always_comb begin
        stream_and = 1'b1;
        any_zero   = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (odo_q[i*DATA_WIDTH +: DATA_WIDTH] >= x_q[i]) stream_and = 1'b0;
            if (x_q[i] == '0) any_zero = 1'b1;
        end
    end

    assign last = &odo_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        odo_d    = odo_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    x_d     = bus.bin_data_in;
                    odo_d   = '0;
                    acc_d   = '0;
                end
            end
            StRun: begin
                if (bus.en) begin
                    acc_d = acc_q + OUT_WIDTH'(stream_and);
                    odo_d = odo_q + OUT_WIDTH'(1);
                    if (last || (EARLY_ZERO && any_zero)) begin
                        state_d  = StDone;
                        result_d = acc_d;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            x_q      <= '{default: '0};
            odo_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            odo_q    <= odo_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.busy         = (state_q == StRun);
    assign bus.done         = (state_q == StDone);
    assign bus.bin_data_out = result_q;
endmodule
